// File: rtl/nn_feeder_if.sv
// Host/core bundle for the neural-network feeder.
// The master modport is the feeder: it consumes host requests and
// drives the core-facing instruction and lane signals.
interface nn_feeder_if #(
    parameter int DATA_W = 16
) ();
    logic                     host_valid;
    logic                     host_ready;
    logic signed [DATA_W-1:0] host_data_1;
    logic signed [DATA_W-1:0] host_data_2;
    logic                     host_go;
    logic                     host_load_weights;
    logic [1:0]               host_act_sel;
    logic [4:0]               instruction;
    logic signed [DATA_W-1:0] nn_data_in_1;
    logic signed [DATA_W-1:0] nn_data_in_2;
    logic                     nn_valid_in_1;
    logic                     nn_valid_in_2;

    modport master (
        input  host_valid,
        input  host_data_1,
        input  host_data_2,
        input  host_go,
        input  host_load_weights,
        input  host_act_sel,
        output host_ready,
        output instruction,
        output nn_data_in_1,
        output nn_data_in_2,
        output nn_valid_in_1,
        output nn_valid_in_2
    );

    modport slave (
        output host_valid,
        output host_data_1,
        output host_data_2,
        output host_go,
        output host_load_weights,
        output host_act_sel,
        input  host_ready,
        input  instruction,
        input  nn_data_in_1,
        input  nn_data_in_2,
        input  nn_valid_in_1,
        input  nn_valid_in_2
    );
endinterface

// File: rtl/nn_feeder.sv
// Host-side feeder for the 2x2 neural-network core.
// Buffers host vectors in a small FIFO, issues the instruction word and
// streams each vector into the two core lanes, lane 2 skewed one cycle
// behind lane 1. Every core-facing output comes straight from a flop.
module nn_feeder #(
    parameter  int DEPTH  = 4,
    parameter  int DATA_W = 16,
    localparam int CNT_W  = $clog2(DEPTH + 1),
    localparam int PTR_W  = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    nn_feeder_if.master      bus,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] fifo_count
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WLOAD  = 2'd1,
        S_STREAM = 2'd2,
        S_DRAIN  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    state_t                   state_q, state_d;
    logic                     pend_q, pend_d;
    logic [1:0]               act_q, act_d;
    logic signed [DATA_W-1:0] mem1_q [DEPTH];
    logic signed [DATA_W-1:0] mem1_d [DEPTH];
    logic signed [DATA_W-1:0] mem2_q [DEPTH];
    logic signed [DATA_W-1:0] mem2_d [DEPTH];
    logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]         count_q, count_d;
    logic signed [DATA_W-1:0] lane1_q, lane1_d;
    logic signed [DATA_W-1:0] lane2_q, lane2_d;
    logic signed [DATA_W-1:0] skew_q, skew_d;
    logic                     vld1_q, vld1_d;
    logic                     vld2_q, vld2_d;
    logic                     start_q, start_d;
    logic                     wload_q, wload_d;
    logic                     linp_q, linp_d;
    logic [1:0]               act_out_q, act_out_d;
    logic                     done_q, done_d;

    logic full;
    logic empty;
    logic push;
    logic pop;

    assign full  = (count_q == CNT_FULL);
    assign empty = (count_q == '0);
    assign push  = bus.host_valid && !full;

    // Next-state, pop decision and registered core-facing outputs.
    // The pop and the lane-1 load happen on the edge that enters or stays
    // in STREAM, so lane 1 is valid in the first cycle of the burst.
    always_comb begin
        state_d   = state_q;
        pend_d    = pend_q;
        act_d     = act_q;
        wload_d   = 1'b0;
        done_d    = 1'b0;
        pop       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.host_load_weights) begin
                    state_d = S_WLOAD;
                    wload_d = 1'b1;
                    if (bus.host_go && !empty) begin
                        pend_d = 1'b1;
                        act_d  = bus.host_act_sel;
                    end
                end else if (bus.host_go && !empty) begin
                    state_d = S_STREAM;
                    act_d   = bus.host_act_sel;
                    pop     = 1'b1;
                end
            end
            S_WLOAD: begin
                pend_d = 1'b0;
                if (pend_q && !empty) begin
                    state_d = S_STREAM;
                    pop     = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_STREAM: begin
                if (!empty) begin
                    pop = 1'b1;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // nn_start marks only the pop that opens a burst
        start_d = pop && (state_q != S_STREAM);

        lane1_d = '0;
        vld1_d  = 1'b0;
        skew_d  = skew_q;
        if (pop) begin
            lane1_d = mem1_q[rd_ptr_q];
            vld1_d  = 1'b1;
            skew_d  = mem2_q[rd_ptr_q];
        end

        // Lane 2 replays the element popped on the previous STREAM edge
        vld2_d  = (state_q == S_STREAM);
        lane2_d = vld2_d ? skew_q : '0;

        linp_d    = vld1_d || vld2_d;
        act_out_d = ((state_d == S_STREAM) || (state_d == S_DRAIN)) ? act_d : 2'b00;
    end

    // FIFO storage, pointers and occupancy
    always_comb begin
        mem1_d   = mem1_q;
        mem2_d   = mem2_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (push) begin
            mem1_d[wr_ptr_q] = bus.host_data_1;
            mem2_d[wr_ptr_q] = bus.host_data_2;
            wr_ptr_d         = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // Register update; reset clears everything, flushing the FIFO
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            pend_q    <= 1'b0;
            act_q     <= 2'b00;
            for (int i = 0; i < DEPTH; i++) begin
                mem1_q[i] <= '0;
                mem2_q[i] <= '0;
            end
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            lane1_q   <= '0;
            lane2_q   <= '0;
            skew_q    <= '0;
            vld1_q    <= 1'b0;
            vld2_q    <= 1'b0;
            start_q   <= 1'b0;
            wload_q   <= 1'b0;
            linp_q    <= 1'b0;
            act_out_q <= 2'b00;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pend_q    <= pend_d;
            act_q     <= act_d;
            mem1_q    <= mem1_d;
            mem2_q    <= mem2_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            lane1_q   <= lane1_d;
            lane2_q   <= lane2_d;
            skew_q    <= skew_d;
            vld1_q    <= vld1_d;
            vld2_q    <= vld2_d;
            start_q   <= start_d;
            wload_q   <= wload_d;
            linp_q    <= linp_d;
            act_out_q <= act_out_d;
            done_q    <= done_d;
        end
    end

    assign bus.host_ready    = !full;
    assign bus.instruction   = {act_out_q, wload_q, linp_q, start_q};
    assign bus.nn_data_in_1  = lane1_q;
    assign bus.nn_data_in_2  = lane2_q;
    assign bus.nn_valid_in_1 = vld1_q;
    assign bus.nn_valid_in_2 = vld2_q;
    assign busy              = (state_q != S_IDLE);
    assign done              = done_q;
    assign fifo_count        = count_q;

endmodule

// File: tb/tb_nn_feeder.sv
// Directed bench for nn_feeder: reset, bursts, FIFO full, weights+go,
// empty go, mid-stream push and reset mid-burst.
module tb_nn_feeder;
    localparam int DEPTH  = 4;
    localparam int DATA_W = 16;
    localparam int CNT_W  = $clog2(DEPTH + 1);

    logic             clk;
    logic             rst;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] fifo_count;

    int n_checks;
    int n_errors;

    nn_feeder_if #(.DATA_W(DATA_W)) bus ();

    nn_feeder #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .busy       (busy),
        .done       (done),
        .fifo_count (fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic lanes(input string tag, input logic v1, input int d1, input logic v2, input int d2);
        check({tag, ".v1"}, 32'(bus.nn_valid_in_1), 32'(v1));
        check({tag, ".d1"}, 32'(bus.nn_data_in_1), 32'(d1));
        check({tag, ".v2"}, 32'(bus.nn_valid_in_2), 32'(v2));
        check({tag, ".d2"}, 32'(bus.nn_data_in_2), 32'(d2));
    endtask

    task automatic push(input int d1, input int d2);
        bus.host_valid  = 1'b1;
        bus.host_data_1 = DATA_W'(d1);
        bus.host_data_2 = DATA_W'(d2);
        tick();
        bus.host_valid  = 1'b0;
    endtask

    task automatic go(input logic [1:0] sel, input logic lw);
        bus.host_go           = 1'b1;
        bus.host_load_weights = lw;
        bus.host_act_sel      = sel;
        tick();
        bus.host_go           = 1'b0;
        bus.host_load_weights = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst                   = 1'b1;
        bus.host_valid        = 1'b0;
        bus.host_data_1       = '0;
        bus.host_data_2       = '0;
        bus.host_go           = 1'b0;
        bus.host_load_weights = 1'b0;
        bus.host_act_sel      = 2'b00;

        // Reset
        tick();
        tick();
        check("rst.instr", 32'(bus.instruction), 0);
        lanes("rst", 0, 0, 0, 0);
        check("rst.busy", 32'(busy), 0);
        check("rst.done", 32'(done), 0);
        check("rst.ready", 32'(bus.host_ready), 1);
        check("rst.count", 32'(fifo_count), 0);
        rst = 1'b0;
        tick();

        // Three-vector burst, act_sel=01
        push(1, 2);
        push(3, 4);
        push(5, 6);
        check("b3.count", 32'(fifo_count), 3);
        go(2'b01, 1'b0);
        check("b3.c1.instr", 32'(bus.instruction), 32'b01011);
        lanes("b3.c1", 1, 1, 0, 0);
        check("b3.c1.busy", 32'(busy), 1);
        tick();
        check("b3.c2.instr", 32'(bus.instruction), 32'b01010);
        lanes("b3.c2", 1, 3, 1, 2);
        tick();
        lanes("b3.c3", 1, 5, 1, 4);
        tick();
        check("b3.c4.instr", 32'(bus.instruction), 32'b01010);
        lanes("b3.c4", 0, 0, 1, 6);
        check("b3.c4.busy", 32'(busy), 1);
        check("b3.c4.done", 32'(done), 0);
        tick();
        check("b3.c5.done", 32'(done), 1);
        check("b3.c5.busy", 32'(busy), 0);
        check("b3.c5.instr", 32'(bus.instruction), 0);
        lanes("b3.c5", 0, 0, 0, 0);
        tick();
        check("b3.c6.done", 32'(done), 0);

        // FIFO full: five back-to-back pushes, the fifth is dropped
        bus.host_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.host_data_1 = DATA_W'(10 + i);
            bus.host_data_2 = DATA_W'(20 + i);
            tick();
            if (i == 2) begin
                check("full.ready3", 32'(bus.host_ready), 1);
                check("full.count3", 32'(fifo_count), 3);
            end
            if (i == 3) begin
                check("full.ready4", 32'(bus.host_ready), 0);
                check("full.count4", 32'(fifo_count), 4);
            end
        end
        bus.host_valid = 1'b0;
        check("full.ready5", 32'(bus.host_ready), 0);
        check("full.count5", 32'(fifo_count), 4);
        go(2'b11, 1'b0);
        check("full.c1.ready", 32'(bus.host_ready), 1);
        check("full.c1.instr", 32'(bus.instruction), 32'b11011);
        lanes("full.c1", 1, 10, 0, 0);
        tick();
        lanes("full.c2", 1, 11, 1, 20);
        tick();
        lanes("full.c3", 1, 12, 1, 21);
        tick();
        lanes("full.c4", 1, 13, 1, 22);
        tick();
        lanes("full.c5", 0, 0, 1, 23);
        tick();
        check("full.c6.done", 32'(done), 1);
        check("full.c6.count", 32'(fifo_count), 0);
        tick();

        // Weights together with go, one vector buffered
        push(7, 8);
        go(2'b10, 1'b1);
        check("wg.c1.instr", 32'(bus.instruction), 32'b00100);
        lanes("wg.c1", 0, 0, 0, 0);
        check("wg.c1.busy", 32'(busy), 1);
        tick();
        check("wg.c2.instr", 32'(bus.instruction), 32'b10011);
        lanes("wg.c2", 1, 7, 0, 0);
        tick();
        check("wg.c3.instr", 32'(bus.instruction), 32'b10010);
        lanes("wg.c3", 0, 0, 1, 8);
        check("wg.c3.done", 32'(done), 0);
        tick();
        check("wg.c4.done", 32'(done), 1);
        check("wg.c4.instr", 32'(bus.instruction), 0);
        tick();

        // Go with an empty FIFO is ignored
        go(2'b01, 1'b0);
        check("empty.busy", 32'(busy), 0);
        check("empty.instr", 32'(bus.instruction), 0);
        tick();
        check("empty.busy2", 32'(busy), 0);

        // Load weights alone: one WLOAD cycle, back to IDLE
        go(2'b00, 1'b1);
        bus.host_go = 1'b0;
        check("lw.c1.instr", 32'(bus.instruction), 32'b00100);
        tick();
        check("lw.c2.instr", 32'(bus.instruction), 0);
        check("lw.c2.busy", 32'(busy), 0);

        // Push during STREAM joins the running burst
        push(1, 2);
        push(3, 4);
        go(2'b11, 1'b0);
        lanes("mid.c1", 1, 1, 0, 0);
        check("mid.c1.count", 32'(fifo_count), 1);
        push(5, 6);
        lanes("mid.c2", 1, 3, 1, 2);
        check("mid.c2.count", 32'(fifo_count), 1);
        tick();
        lanes("mid.c3", 1, 5, 1, 4);
        check("mid.c3.count", 32'(fifo_count), 0);
        tick();
        lanes("mid.c4", 0, 0, 1, 6);
        check("mid.c4.instr", 32'(bus.instruction), 32'b11010);
        tick();
        check("mid.c5.done", 32'(done), 1);
        tick();

        // Reset in cycle 2 of a 4-vector burst
        for (int i = 0; i < 4; i++) push(40 + i, 50 + i);
        go(2'b01, 1'b0);
        lanes("rmb.c1", 1, 40, 0, 0);
        tick();
        lanes("rmb.c2", 1, 41, 1, 50);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        lanes("rmb.c3", 0, 0, 0, 0);
        check("rmb.c3.count", 32'(fifo_count), 0);
        check("rmb.c3.instr", 32'(bus.instruction), 0);
        check("rmb.c3.busy", 32'(busy), 0);
        check("rmb.c3.done", 32'(done), 0);
        check("rmb.c3.ready", 32'(bus.host_ready), 1);
        tick();
        check("rmb.c4.done", 32'(done), 0);
        check("rmb.c4.busy", 32'(busy), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
